lsu: RTL and testbench

Load/store unit for the cotm32 core: consumes the `lsu_ls_t` command produced by the control unit for LOAD/STORE instructions, the ALU-computed effective address and the rs2 value, and runs a request/grant/response transaction on the data-memory port. It aligns store data with byte enables, sign- or zero-extends load data for `REG_WB_LSU` write-back, flags misaligned accesses, and stalls the core while a transaction is in flight.

---
 rtl/cotm32_pkg.sv | 38 +++
 rtl/lsu_align.sv | 55 +++++
 rtl/lsu.sv | 113 +++++++++++
 tb/tb_lsu.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cotm32_pkg.sv
// cotm32 shared types and constants.
// Load/store command encoding, LSU state enum and helpers.
package cotm32_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] LS_F3_B  = 3'b000;
    localparam logic [2:0] LS_F3_H  = 3'b001;
    localparam logic [2:0] LS_F3_W  = 3'b010;
    localparam logic [2:0] LS_F3_BU = 3'b100;
    localparam logic [2:0] LS_F3_HU = 3'b101;

    // {is_store, funct3}; LSU_NONE uses an encoding no access can have
    typedef enum logic [3:0] {
        LSU_LB   = {1'b0, LS_F3_B},
        LSU_LH   = {1'b0, LS_F3_H},
        LSU_LW   = {1'b0, LS_F3_W},
        LSU_LBU  = {1'b0, LS_F3_BU},
        LSU_LHU  = {1'b0, LS_F3_HU},
        LSU_SB   = {1'b1, LS_F3_B},
        LSU_SH   = {1'b1, LS_F3_H},
        LSU_SW   = {1'b1, LS_F3_W},
        LSU_NONE = 4'b1111
    } lsu_ls_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        DONE,
        ERR
    } lsu_state_t;

    function automatic logic lsu_is_load(lsu_ls_t op);
        return (op != LSU_NONE) && !op[3];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Store lane steering, byte enables, load extension
// and misalignment detection for the cotm32 LSU.
module lsu_align
    import cotm32_pkg::*;
(
    input  logic [2:0]      f3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] st_in,
    input  logic [XLEN-1:0] ld_in,
    output logic [3:0]      be,
    output logic [XLEN-1:0] st_out,
    output logic [XLEN-1:0] ld_out,
    output logic            misaligned
);

    logic            is_b;
    logic            is_h;
    logic            is_w;
    logic            sext;
    logic [XLEN-1:0] sh;

    assign is_b = (f3[1:0] == 2'b00);
    assign is_h = (f3[1:0] == 2'b01);
    assign is_w = (f3[1:0] == 2'b10);
    assign sext = ~f3[2];
    assign sh   = ld_in >> {off, 3'b000};

    always_comb begin
        be         = 4'b0000;
        st_out     = st_in;
        ld_out     = ld_in;
        misaligned = 1'b0;
        unique case (1'b1)
            is_b: begin
                be     = 4'b0001 << off;
                st_out = {4{st_in[7:0]}};
                ld_out = {{24{sext & sh[7]}}, sh[7:0]};
            end
            is_h: begin
                be         = 4'b0011 << off;
                st_out     = {2{st_in[15:0]}};
                ld_out     = {{16{sext & sh[15]}}, sh[15:0]};
                misaligned = off[0];
            end
            is_w: begin
                be         = 4'b1111;
                misaligned = (off != 2'b00);
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// cotm32 load/store unit: request/grant/response FSM
// driving the data-memory port.
module lsu
    import cotm32_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  lsu_ls_t         i_lsu_ls,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_stall,
    output logic            o_done,
    output logic            o_misaligned,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_mem_req,
    input  logic            i_mem_gnt,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [3:0]      o_mem_be,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata
);

    lsu_state_t      state;
    lsu_ls_t         op_q;
    logic [1:0]      off_q;
    lsu_ls_t         op_sel;
    logic [1:0]      off_sel;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_st;
    logic [XLEN-1:0] al_ld;
    logic            al_mis;
    logic            accept;

    assign accept  = (state == IDLE) && (i_lsu_ls != LSU_NONE);
    // Live inputs while accepting, latched command for the response
    assign op_sel  = (state == IDLE) ? i_lsu_ls : op_q;
    assign off_sel = (state == IDLE) ? i_addr[1:0] : off_q;

    assign o_stall = accept || (state == REQ) || (state == RESP);

    lsu_align u_align (
        .f3         (op_sel[2:0]),
        .off        (off_sel),
        .st_in      (i_wdata),
        .ld_in      (i_mem_rdata),
        .be         (al_be),
        .st_out     (al_st),
        .ld_out     (al_ld),
        .misaligned (al_mis)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            op_q         <= LSU_NONE;
            off_q        <= 2'b00;
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            o_rdata      <= '0;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_be     <= 4'b0000;
            o_mem_wdata  <= '0;
        end else begin
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q        <= i_lsu_ls;
                        off_q       <= i_addr[1:0];
                        o_mem_we    <= !lsu_is_load(i_lsu_ls);
                        o_mem_addr  <= {i_addr[XLEN-1:2], 2'b00};
                        o_mem_be    <= al_be;
                        o_mem_wdata <= al_st;
                        if (al_mis) begin
                            state        <= ERR;
                            o_misaligned <= 1'b1;
                        end else begin
                            state     <= REQ;
                            o_mem_req <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (i_mem_gnt) begin
                        o_mem_req <= 1'b0;
                        if (o_mem_we) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (i_mem_rvalid) begin
                        o_rdata <= al_ld;
                        state   <= DONE;
                        o_done  <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                ERR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed-vector bench for the cotm32 load/store unit.
// Each task drives one scenario and checks inline.
module tb_lsu;
    import cotm32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    lsu_ls_t     ls;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        mis;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    lsu dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_lsu_ls     (ls),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_stall      (stall),
        .o_done       (done),
        .o_misaligned (mis),
        .o_rdata      (rdata),
        .o_mem_req    (mem_req),
        .i_mem_gnt    (mem_gnt),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_be     (mem_be),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ls = LSU_NONE; addr = '0; wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        nvec++;
        if ({mem_req, mem_we, done, mis, stall} !== 5'b0) begin
            nerr++;
            $display("FAIL reset_ctl got=%b want=00000",
                     {mem_req, mem_we, done, mis, stall});
        end
        nvec++;
        if ({rdata, mem_addr, mem_wdata, mem_be} !== 100'h0) begin
            nerr++;
            $display("FAIL reset_data rdata=%h addr=%h wd=%h be=%b want 0",
                     rdata, mem_addr, mem_wdata, mem_be);
        end
        tick();
    endtask

    task automatic test_store_byte();
        ls = LSU_SB; addr = 32'h1003; wdata = 32'h0000_00A5; mem_gnt = 1'b1;
        #1;
        nvec++;
        if (stall !== 1'b1) begin
            nerr++; $display("FAIL sb_stall_c1 got=%b want=1", stall);
        end
        tick();
        nvec++;
        if ({mem_req, mem_we, stall, done} !== 4'b1110 ||
            mem_addr !== 32'h1000 || mem_be !== 4'b1000 ||
            mem_wdata !== 32'hA5A5A5A5) begin
            nerr++;
            $display("FAIL sb_req got req/we/stall/done=%b addr=%h be=%b wd=%h want 1110 1000 1000 a5a5a5a5",
                     {mem_req, mem_we, stall, done}, mem_addr, mem_be, mem_wdata);
        end
        tick();
        nvec++;
        if ({done, stall, mem_req} !== 3'b100) begin
            nerr++; $display("FAIL sb_done got done/stall/req=%b want=100",
                             {done, stall, mem_req});
        end
        ls = LSU_NONE; mem_gnt = 1'b0;
        tick();
        nvec++;
        if ({done, stall} !== 2'b00) begin
            nerr++; $display("FAIL sb_after got done/stall=%b want=00", {done, stall});
        end
    endtask

    task automatic test_loads();
        lsu_ls_t     ops [5] = '{LSU_LB, LSU_LBU, LSU_LHU, LSU_LH, LSU_LW};
        logic [31:0] adr [5] = '{32'h2001, 32'h2001, 32'h2002, 32'h2002, 32'h2000};
        logic [31:0] mem [5] = '{32'h0000_80FF, 32'h0000_80FF, 32'hBEEF_0000,
                                 32'hBEEF_0000, 32'h1234_5678};
        logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_BEEF,
                                 32'hFFFF_BEEF, 32'h1234_5678};
        logic [3:0]  ebe [5] = '{4'b0010, 4'b0010, 4'b1100, 4'b1100, 4'b1111};
        for (int i = 0; i < 5; i++) begin
            ls = ops[i]; addr = adr[i]; mem_gnt = 1'b1;
            tick();
            nvec++;
            if ({mem_req, mem_we} !== 2'b10 || mem_be !== ebe[i] ||
                mem_addr !== {adr[i][31:2], 2'b00}) begin
                nerr++;
                $display("FAIL ld%0d_req req/we=%b be=%b addr=%h want 10 %b",
                         i, {mem_req, mem_we}, mem_be, mem_addr, ebe[i]);
            end
            tick();
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = mem[i];
            #1;
            nvec++;
            if ({stall, done, mem_req} !== 3'b100) begin
                nerr++; $display("FAIL ld%0d_resp stall/done/req=%b want=100",
                                 i, {stall, done, mem_req});
            end
            tick();
            mem_rvalid = 1'b0; mem_rdata = 32'h0;
            nvec++;
            if (done !== 1'b1 || stall !== 1'b0 || rdata !== exp[i]) begin
                nerr++;
                $display("FAIL ld%0d_data done=%b stall=%b rdata=%h want 1 0 %h",
                         i, done, stall, rdata, exp[i]);
            end
            ls = LSU_NONE;
            tick();
        end
    endtask

    task automatic test_misaligned();
        ls = LSU_LW; addr = 32'h3002; mem_gnt = 1'b1;
        #1;
        nvec++;
        if (stall !== 1'b1) begin
            nerr++; $display("FAIL mis_stall got=%b want=1", stall);
        end
        tick();
        nvec++;
        if ({mis, mem_req, stall, done} !== 4'b1000 || rdata !== 32'h1234_5678) begin
            nerr++;
            $display("FAIL mis_pulse mis/req/stall/done=%b rdata=%h want 1000 12345678",
                     {mis, mem_req, stall, done}, rdata);
        end
        ls = LSU_NONE; mem_gnt = 1'b0;
        tick();
        nvec++;
        if ({mis, mem_req} !== 2'b00) begin
            nerr++; $display("FAIL mis_after mis/req=%b want=00", {mis, mem_req});
        end
        ls = LSU_SH; addr = 32'h3001;
        tick();
        nvec++;
        if ({mis, mem_req} !== 2'b10) begin
            nerr++; $display("FAIL mis_sh mis/req=%b want=10", {mis, mem_req});
        end
        ls = LSU_NONE;
        tick();
    endtask

    task automatic test_gnt_wait();
        ls = LSU_SW; addr = 32'h4000; wdata = 32'hDEAD_BEEF; mem_gnt = 1'b0;
        tick();
        addr = 32'h9999_9999; wdata = 32'h0BAD_0BAD; ls = LSU_SB;
        for (int c = 0; c < 5; c++) begin
            #1;
            nvec++;
            if ({mem_req, mem_we, stall, done} !== 4'b1110 ||
                mem_addr !== 32'h4000 || mem_wdata !== 32'hDEAD_BEEF ||
                mem_be !== 4'b1111) begin
                nerr++;
                $display("FAIL gnt_hold%0d ctl=%b addr=%h wd=%h be=%b want 1110 4000 deadbeef 1111",
                         c, {mem_req, mem_we, stall, done}, mem_addr, mem_wdata, mem_be);
            end
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        nvec++;
        if ({done, stall, mem_req} !== 3'b100) begin
            nerr++; $display("FAIL gnt_done done/stall/req=%b want=100",
                             {done, stall, mem_req});
        end
        ls = LSU_NONE;
        tick();
    endtask

    task automatic test_reset_mid();
        ls = LSU_LW; addr = 32'h5000; mem_gnt = 1'b1;
        tick();
        tick();
        mem_gnt = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; ls = LSU_NONE;
        #1;
        nvec++;
        if ({mem_req, stall, done} !== 3'b000) begin
            nerr++; $display("FAIL rstmid_idle req/stall/done=%b want=000",
                             {mem_req, stall, done});
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0;
        nvec++;
        if (done !== 1'b0 || rdata !== 32'h0) begin
            nerr++; $display("FAIL rstmid_late done=%b rdata=%h want 0 00000000",
                             done, rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        ls = LSU_LW; addr = 32'h6004; mem_gnt = 1'b1;
        tick();
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        nvec++;
        if (done !== 1'b1 || rdata !== 32'hCAFE_F00D) begin
            nerr++; $display("FAIL b2b_ld done=%b rdata=%h want 1 cafef00d", done, rdata);
        end
        tick();
        ls = LSU_SW; addr = 32'h6008; wdata = 32'h1122_3344; mem_gnt = 1'b1;
        #1;
        nvec++;
        if (stall !== 1'b1 || done !== 1'b0) begin
            nerr++; $display("FAIL b2b_accept stall=%b done=%b want 1 0", stall, done);
        end
        tick();
        nvec++;
        if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h6008 ||
            mem_wdata !== 32'h1122_3344) begin
            nerr++;
            $display("FAIL b2b_st req/we=%b addr=%h wd=%h want 11 6008 11223344",
                     {mem_req, mem_we}, mem_addr, mem_wdata);
        end
        tick();
        nvec++;
        if (done !== 1'b1 || rdata !== 32'hCAFE_F00D) begin
            nerr++; $display("FAIL b2b_done done=%b rdata=%h want 1 cafef00d", done, rdata);
        end
        ls = LSU_NONE; mem_gnt = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_loads();
        test_misaligned();
        test_gnt_wait();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
